// File: rtl/multicycle_mips.sv
// multicycle_mips: 5-state multi-cycle MIPS core; ports: CLK/RST, ROM via IR_addr/IR, SRAM via CEN/WEN/OEN/A/ReadData2/ReadDataMem/DM_ready, trace via RF_we/RF_writedata/retire
module multicycle_mips #(
  parameter int DADDR_W = 7,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic               CLK,
  input  logic               RST,
  output logic [31:0]        IR_addr,
  input  logic [31:0]        IR,
  output logic [31:0]        RF_writedata,
  output logic               RF_we,
  output logic               retire,
  output logic               CEN,
  output logic               WEN,
  output logic               OEN,
  output logic [DADDR_W-1:0] A,
  output logic [31:0]        ReadData2,
  input  logic [31:0]        ReadDataMem,
  input  logic               DM_ready
);
  typedef enum logic [2:0] {S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB} state_t;
  state_t state;
  logic [31:0] pc, ir, a_q, b_q, alu_q, mdr_q;
  logic [31:0] rf [32];
  logic [5:0] op, fn;
  logic [4:0] rs, rt, rd, wb_dest;
  logic [31:0] simm, opb, alu_res, br_tgt, j_tgt, next_pc;
  logic is_r, is_add, is_sub, is_and, is_or, is_slt, is_jr, is_alu;
  logic is_lw, is_sw, is_beq, is_addi, is_j, is_jal, goes_wb;
  assign op = ir[31:26];
  assign rs = ir[25:21];
  assign rt = ir[20:16];
  assign rd = ir[15:11];
  assign fn = ir[5:0];
  assign simm = {{16{ir[15]}}, ir[15:0]};
  assign is_r = op == 6'h00;
  assign is_add = is_r && fn == 6'h20;
  assign is_sub = is_r && fn == 6'h22;
  assign is_and = is_r && fn == 6'h24;
  assign is_or = is_r && fn == 6'h25;
  assign is_slt = is_r && fn == 6'h2A;
  assign is_jr = is_r && fn == 6'h08;
  assign is_alu = is_add || is_sub || is_and || is_or || is_slt;
  assign is_lw = op == 6'h23;
  assign is_sw = op == 6'h2B;
  assign is_beq = op == 6'h04;
  assign is_addi = op == 6'h08;
  assign is_j = op == 6'h02;
  assign is_jal = op == 6'h03;
  assign goes_wb = is_alu || is_addi || is_lw;
  assign opb = is_r ? b_q : simm;
  assign alu_res = is_sub ? a_q - b_q :
                   is_and ? a_q & b_q :
                   is_or  ? a_q | b_q :
                   is_slt ? {31'b0, $signed(a_q) < $signed(b_q)} :
                   a_q + opb;
  // pc already holds PC+4 once fetch has completed
  assign br_tgt = pc + {simm[29:0], 2'b00};
  assign j_tgt = {pc[31:28], ir[25:0], 2'b00};
  assign next_pc = (is_beq && a_q == b_q) ? br_tgt : (is_j || is_jal) ? j_tgt : is_jr ? a_q : pc;
  // jal is the only write issued from S_EXEC
  assign wb_dest = state == S_EXEC ? 5'd31 : is_r ? rd : rt;
  assign RF_we = (state == S_EXEC && is_jal) || (state == S_WB && wb_dest != 5'd0);
  assign RF_writedata = !RF_we ? 32'd0 : state == S_EXEC ? pc : is_lw ? mdr_q : alu_q;
  assign retire = (state == S_EXEC && !(goes_wb || is_sw)) || (state == S_MEM && is_sw && DM_ready) || state == S_WB;
  assign CEN = state != S_MEM;
  assign WEN = !(state == S_MEM && is_sw);
  assign OEN = !(state == S_MEM && is_lw);
  assign A = alu_q[DADDR_W+1:2];
  assign ReadData2 = b_q;
  assign IR_addr = pc;
  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= S_FETCH;
      pc <= RESET_PC;
      ir <= '0;
      a_q <= '0;
      b_q <= '0;
      alu_q <= '0;
      mdr_q <= '0;
      for (int i = 0; i < 32; i++) rf[i] <= '0;
    end else begin
      if (RF_we) rf[wb_dest] <= RF_writedata;
      case (state)
        S_FETCH: begin
          ir <= IR;
          pc <= pc + 32'd4;
          state <= S_DECODE;
        end
        S_DECODE: begin
          a_q <= rf[rs];
          b_q <= rf[rt];
          state <= S_EXEC;
        end
        S_EXEC: begin
          alu_q <= alu_res;
          pc <= next_pc;
          state <= (is_lw || is_sw) ? S_MEM : goes_wb ? S_WB : S_FETCH;
        end
        S_MEM: if (DM_ready) begin
          mdr_q <= ReadDataMem;
          state <= is_lw ? S_WB : S_FETCH;
        end
        S_WB: state <= S_FETCH;
        default: state <= S_FETCH;
      endcase
    end
  end
endmodule
